fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: data widths, PC step
// and the fetch FSM state encoding.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer for the fetch unit: power-of-two depth FIFO with a
// synchronous flush. The head entry is read straight out of the storage
// registers, so it is stable for the whole cycle after a push lands.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; flush discards everything at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word-aligned request at a time to the
// instruction memory, buffers responses with their addresses, and presents
// them to the decoder. Redirects flush the buffer and restart fetching.
// Optional build macro FETCH_PERF_CNT_EN adds the perf_fetch_cnt output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt
`endif
);

    fetch_state_t          state_q;
    logic [PC_W-1:0]       pc_q;
    logic [PC_W-1:0]       redir_pc;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [PC_W+INSTR_W-1:0] head_data;

    assign redir_pc    = redirect_pc & ~PC_W'(3);
    // imem_addr still holds the granted address while the response is awaited
    assign fifo_push   = (state_q == WAIT) && imem_rvalid && !redirect;
    assign fifo_pop    = instr_valid && instr_ready;
    assign instr_valid = !fifo_empty;
    assign {instr_pc, instr} = head_data;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (fifo_push),
        .push_data ({imem_addr, imem_rdata}),
        .pop       (fifo_pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fetch FSM with registered request outputs; redirect overrides all else.
    // A response arriving together with a redirect in DROP still ends DROP,
    // since that is the one outstanding response being waited for.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (redirect) begin
                        pc_q <= redir_pc;
                    end else if (!fifo_full) begin
                        imem_req  <= 1'b1;
                        imem_addr <= pc_q;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        pc_q     <= redir_pc;
                        imem_req <= 1'b0;
                        state_q  <= imem_gnt ? DROP : IDLE;
                    end else if (imem_gnt) begin
                        pc_q     <= pc_q + PC_W'(PC_STEP);
                        imem_req <= 1'b0;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc_q    <= redir_pc;
                        state_q <= imem_rvalid ? IDLE : DROP;
                    end else if (imem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc_q <= redir_pc;
                    end
                    if (imem_rvalid) begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count instructions handed to the decoder, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
        end else if (fifo_pop) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed sequences for the corner
// cases, a table of redirect targets, and a randomized run against a
// program-order scoreboard of the fetch stream.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    int vectors = 0;
    int miscompares = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory content: a fixed scramble of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        redirect = 1'b0;
        redirect_pc = '0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check({name, "_req"}, 32'(imem_req), 32'd1);
    endtask

    // Grant the pending request, then return its word one cycle later
    task automatic issue_resp(input logic [31:0] a);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(a);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata = '0;
    endtask

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] addr;
        logic [31:0] next_addr;
    } redir_vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } dec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        killed;
    } out_t;

    dec_t expq[$];
    out_t outq[$];

    initial begin
        redir_vec_t  tbl [5];
        logic [31:0] a;
        logic [1:0]  st;
        bit          req_seen;
        logic [31:0] exp_fetch;
        bit          pend;
        int          lat;
        int          pops;
        bit          prev_req, prev_gnt, prev_redir;
        logic [31:0] prev_addr;
        bit          rdy, redir, g, rv;
        logic [31:0] tgt;
        dec_t        d;
        out_t        o;

        tbl[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0104};
        tbl[1] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
        tbl[2] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[4] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0004};

        // Reset values and in-order fetch with immediate grant
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        rst_n = 1'b1;
        instr_ready = 1'b1;
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            wait_req("seq");
            check("seq_addr", imem_addr, a);
            issue_resp(a);
            check("seq_valid", 32'(instr_valid), 32'd1);
            check("seq_instr", instr, mem_word(a));
            check("seq_instr_pc", instr_pc, a);
        end

        // Decoder stalled: buffer fills, requests stop until one pop
        do_reset();
        instr_ready = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            a = 32'(i * 4);
            wait_req("fill");
            check("fill_addr", imem_addr, a);
            issue_resp(a);
        end
        req_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req) req_seen = 1'b1;
            tick();
        end
        check("full_no_req", 32'(req_seen), 32'd0);
        check("full_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("pop_head_pc", instr_pc, 32'h4);
        wait_req("refill");
        check("refill_addr", imem_addr, 32'h8);
        issue_resp(32'h8);
        instr_ready = 1'b1;
        tick();
        tick();
        check("drain_valid", 32'(instr_valid), 32'd0);

        // Redirect while waiting, stale response two cycles later
        do_reset();
        tick();
        wait_req("w_redir");
        check("w_redir_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("w_redir_flush", 32'(instr_valid), 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0;
        check("stale_valid", 32'(instr_valid), 32'd0);
        wait_req("w_redir_next");
        check("stale_valid2", 32'(instr_valid), 32'd0);
        check("w_redir_next_addr", imem_addr, 32'h100);
        issue_resp(32'h100);
        check("w_redir_instr_pc", instr_pc, 32'h100);
        check("w_redir_instr", instr, mem_word(32'h100));

        // Redirect coincident with grant
        do_reset();
        tick();
        wait_req("g_redir");
        imem_gnt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        tick();
        imem_gnt = 1'b0;
        redirect = 1'b0;
        st = dut.state_q;
        check("g_redir_drop", 32'(st), 32'(DROP));
        check("g_redir_noreq", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(32'h0);
        tick();
        imem_rvalid = 1'b0;
        check("g_redir_dropped", 32'(instr_valid), 32'd0);
        wait_req("g_redir_next");
        check("g_redir_next_addr", imem_addr, 32'h200);
        issue_resp(32'h200);
        check("g_redir_instr_pc", instr_pc, 32'h200);

        // Redirect target table: alignment and 32-bit wrap of the PC
        for (int i = 0; i < 5; i++) begin
            do_reset();
            redirect = 1'b1;
            redirect_pc = tbl[i].tgt;
            tick();
            redirect = 1'b0;
            check("tbl_noreq", 32'(imem_req), 32'd0);
            wait_req("tbl");
            check("tbl_addr", imem_addr, tbl[i].addr);
            issue_resp(tbl[i].addr);
            check("tbl_instr_pc", instr_pc, tbl[i].addr);
            wait_req("tbl_next");
            check("tbl_next_addr", imem_addr, tbl[i].next_addr);
        end

        // Reset in the middle of a transaction, response arrives afterwards
        do_reset();
        tick();
        wait_req("r_mid");
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rmid_req", 32'(imem_req), 32'd0);
        check("rmid_addr", imem_addr, 32'h0);
        check("rmid_valid", 32'(instr_valid), 32'd0);
        check("rmid_instr", instr, 32'h0);
        check("rmid_instr_pc", instr_pc, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata = mem_word(32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        imem_rvalid = 1'b0;
        check("rmid_post_valid", 32'(instr_valid), 32'd0);
        check("rmid_post_req", 32'(imem_req), 32'd1);
        check("rmid_post_addr", imem_addr, 32'h0);
        tick();
        tick();
        check("rmid_post_valid2", 32'(instr_valid), 32'd0);

        // Randomized run against a program-order scoreboard
        do_reset();
        expq.delete();
        outq.delete();
        exp_fetch = 32'h0;
        pend = 1'b0;
        lat = 0;
        pops = 0;
        prev_req = 1'b0;
        prev_gnt = 1'b0;
        prev_redir = 1'b0;
        prev_addr = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd_valid", 32'(instr_valid), 32'(expq.size() != 0));
            if (instr_valid && expq.size() != 0) begin
                check("rnd_instr_pc", instr_pc, expq[0].pc);
                check("rnd_instr", instr, expq[0].data);
            end
            if (prev_req && !prev_gnt && !prev_redir) begin
                check("rnd_req_hold", 32'(imem_req), 32'd1);
                check("rnd_addr_hold", imem_addr, prev_addr);
            end

            rdy   = ($urandom_range(0, 3) != 0);
            redir = ($urandom_range(0, 19) == 0);
            tgt   = $urandom;
            g     = imem_req && ($urandom_range(0, 2) != 0);
            rv    = pend && (lat == 0);
            if (pend && lat != 0) lat--;

            instr_ready = rdy;
            redirect = redir;
            redirect_pc = tgt;
            imem_gnt = g;
            imem_rvalid = rv;
            imem_rdata = '0;

            if (instr_valid && rdy && !redir && expq.size() != 0) begin
                void'(expq.pop_front());
                pops++;
            end
            if (rv) begin
                o = outq.pop_front();
                imem_rdata = mem_word(o.addr);
                pend = 1'b0;
                if (!o.killed && !redir) begin
                    d.pc = o.addr;
                    d.data = mem_word(o.addr);
                    expq.push_back(d);
                end
            end
            if (imem_req && g) begin
                check("rnd_req_addr", imem_addr, exp_fetch);
                o.addr = imem_addr;
                o.killed = 1'b0;
                outq.push_back(o);
                exp_fetch = imem_addr + 32'd4;
                pend = 1'b1;
                lat = int'($urandom_range(0, 2));
            end
            if (redir) begin
                expq.delete();
                foreach (outq[k]) outq[k].killed = 1'b1;
                exp_fetch = tgt & ~32'h3;
            end

            prev_req = imem_req;
            prev_gnt = g;
            prev_redir = redir;
            prev_addr = imem_addr;
            tick();
        end
        check("rnd_progress", 32'(pops > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
